// File: rtl/regfile_2r1w_fwd.sv
// Two-read/one-write register file with byte enables, optional write-to-read
// bypass, hardwired-zero entry 0 and a multi-cycle sweep-clear controller.
module regfile_2r1w_fwd #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  re1,
  input  logic [ADDR_W-1:0]     raddr1,
  input  logic                  re2,
  input  logic [ADDR_W-1:0]     raddr2,
  input  logic                  fwd_en,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned AW1 = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  clr_done_q, clr_done_d;
  logic [DATA_W-1:0]     rdata1_q, rdata1_d;
  logic [DATA_W-1:0]     rdata2_q, rdata2_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];

  logic                  wr_ok;
  logic [DATA_W-1:0]     old_w, old_r1, old_r2, wmerge;

  // Address is backed by storage and not the hardwired-zero entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < AW1'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  assign rdata1   = rdata1_q;
  assign rdata2   = rdata2_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  // Sweep FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Sweep FSM: next state; requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sweep FSM: registered outputs; busy drops as DONE is entered so it spans DEPTH cycles.
  always_comb begin
    cnt_d      = cnt_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          cnt_d      = '0;
          clr_busy_d = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Array update, byte merge and registered read ports with optional bypass.
  always_comb begin
    old_w  = '0;
    old_r1 = '0;
    old_r2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (waddr  == ADDR_W'(i)) old_w  = mem_q[i];
      if (raddr1 == ADDR_W'(i)) old_r1 = mem_q[i];
      if (raddr2 == ADDR_W'(i)) old_r2 = mem_q[i];
    end

    wr_ok = we && !clr_busy_q && addr_ok(waddr) && (|wbe);

    wmerge = old_w;
    for (int unsigned k = 0; k < NB; k++) begin
      if (wbe[k]) wmerge[8*k +: 8] = wdata[8*k +: 8];
    end

    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_ok && (waddr == ADDR_W'(i))) mem_d[i] = wmerge;
      if ((state_q == CLEAR) && (cnt_q == ADDR_W'(i))) mem_d[i] = '0;
    end

    rdata1_d = rdata1_q;
    if (re1) begin
      if (!addr_ok(raddr1))                          rdata1_d = '0;
      else if (fwd_en && wr_ok && (raddr1 == waddr)) rdata1_d = wmerge;
      else                                           rdata1_d = old_r1;
    end

    rdata2_d = rdata2_q;
    if (re2) begin
      if (!addr_ok(raddr2))                          rdata2_d = '0;
      else if (fwd_en && wr_ok && (raddr2 == waddr)) rdata2_d = wmerge;
      else                                           rdata2_d = old_r2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_regfile_2r1w_fwd.sv
// Scoreboard bench: stimulus pushes expected read data, a negedge monitor pops
// and compares whenever a read result is due. Second instance has DEPTH=20.
module tb_regfile_2r1w_fwd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Instance A: DEPTH=32
  logic        we, re1, re2, fwd_en, clr_req;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] rdata1, rdata2;
  logic        clr_busy, clr_done;
  // Instance B: DEPTH=20
  logic        web, re1b, re2b, fwd_enb, clr_reqb;
  logic [4:0]  waddrb, raddr1b, raddr2b;
  logic [31:0] wdatab;
  logic [3:0]  wbeb;
  logic [31:0] rdata1b, rdata2b;
  logic        clr_busyb, clr_doneb;

  regfile_2r1w_fwd #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1'b1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2), .fwd_en(fwd_en),
    .rdata1(rdata1), .rdata2(rdata2), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_2r1w_fwd #(.DATA_W(32), .DEPTH(20), .ZERO_REG(1'b1)) u_dut20 (
    .clk(clk), .rst(rst), .we(web), .waddr(waddrb), .wdata(wdatab), .wbe(wbeb),
    .re1(re1b), .raddr1(raddr1b), .re2(re2b), .raddr2(raddr2b), .fwd_en(fwd_enb),
    .rdata1(rdata1b), .rdata2(rdata2b), .clr_req(clr_reqb),
    .clr_busy(clr_busyb), .clr_done(clr_doneb)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] qb[$];
  logic vld1, vld2, vldb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A read issued at an edge produces data visible after that edge.
  always @(posedge clk) begin
    vld1 <= re1;
    vld2 <= re2;
    vldb <= re1b;
  end

  always @(negedge clk) begin
    if (vld1 === 1'b1) begin
      if (q1.size() == 0) check("rd1_unexpected", rdata1, 32'hxxxxxxxx);
      else check("rd1", rdata1, q1.pop_front());
    end
    if (vld2 === 1'b1) begin
      if (q2.size() == 0) check("rd2_unexpected", rdata2, 32'hxxxxxxxx);
      else check("rd2", rdata2, q2.pop_front());
    end
    if (vldb === 1'b1) begin
      if (qb.size() == 0) check("rdb_unexpected", rdata1b, 32'hxxxxxxxx);
      else check("rdb", rdata1b, qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    tick();
    we = 1'b0;
  endtask

  task automatic rd1(input logic [4:0] a, input logic [31:0] e);
    re1 = 1'b1; raddr1 = a; q1.push_back(e);
    tick();
    re1 = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a, input logic [31:0] e);
    re2 = 1'b1; raddr2 = a; q2.push_back(e);
    tick();
    re2 = 1'b0;
  endtask

  task automatic rdb(input logic [4:0] a, input logic [31:0] e);
    re1b = 1'b1; raddr1b = a; fwd_enb = 1'b0; qb.push_back(e);
    tick();
    re1b = 1'b0;
  endtask

  task automatic measure_busy(output int n, output int dn);
    n = 0; dn = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (clr_done === 1'b1) dn++;
      tick();
      n++;
    end
  endtask

  int n, dn;

  initial begin
    rst = 1'b0;
    we = 0; re1 = 0; re2 = 0; fwd_en = 0; clr_req = 0;
    waddr = 0; raddr1 = 0; raddr2 = 0; wdata = 0; wbe = 0;
    web = 0; re1b = 0; re2b = 0; fwd_enb = 0; clr_reqb = 0;
    waddrb = 0; raddr1b = 0; raddr2b = 0; wdatab = 0; wbeb = 0;
    repeat (2) tick();
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_busy", 32'(clr_busy), 32'h0);
    check("rst_done", 32'(clr_done), 32'h0);
    rst = 1'b1;
    tick();

    // Basic write then read, and hold with re=0
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    rd1(5'd5, 32'hDEADBEEF);
    wr(5'd5, 32'h0BADF00D, 4'hF);
    check("hold_rdata1", rdata1, 32'hDEADBEEF);
    rd2(5'd5, 32'h0BADF00D);

    // Byte enables, and wbe=0 no-op
    wr(5'd7, 32'h11223344, 4'hF);
    wr(5'd7, 32'hAABBCCDD, 4'h5);
    rd1(5'd7, 32'h11BB33DD);
    wr(5'd7, 32'hFFFFFFFF, 4'h0);
    rd2(5'd7, 32'h11BB33DD);

    // Forwarding on: both ports see new data
    we = 1; waddr = 5'd3; wdata = 32'h12345678; wbe = 4'hF; fwd_en = 1;
    re1 = 1; raddr1 = 5'd3; re2 = 1; raddr2 = 5'd3;
    q1.push_back(32'h12345678); q2.push_back(32'h12345678);
    tick();
    // Forwarding off: both ports see old contents
    waddr = 5'd4; raddr1 = 5'd4; raddr2 = 5'd4; fwd_en = 0;
    q1.push_back(32'h0); q2.push_back(32'h0);
    tick();
    we = 0; re1 = 0; re2 = 0;
    rd1(5'd4, 32'h12345678);
    // Partial forward merges old bytes; port 2 reads elsewhere
    we = 1; waddr = 5'd3; wdata = 32'hAABBCCDD; wbe = 4'hA; fwd_en = 1;
    re1 = 1; raddr1 = 5'd3; re2 = 1; raddr2 = 5'd5;
    q1.push_back(32'hAA34CC78); q2.push_back(32'h0BADF00D);
    tick();
    we = 0; re1 = 0; re2 = 0;
    rd2(5'd3, 32'hAA34CC78);
    // Zero register is never forwarded
    we = 1; waddr = 5'd0; wdata = 32'hDEADBEEF; wbe = 4'hF; fwd_en = 1;
    re1 = 1; raddr1 = 5'd0; re2 = 1; raddr2 = 5'd0;
    q1.push_back(32'h0); q2.push_back(32'h0);
    tick();
    we = 0; re1 = 0; re2 = 0; fwd_en = 0;
    rd1(5'd0, 32'h0);

    // DEPTH=20 instance: out-of-range and zero entry, last valid entry
    web = 1; waddrb = 5'd25; wdatab = 32'hFFFFFFFF; wbeb = 4'hF; fwd_enb = 1;
    re1b = 1; raddr1b = 5'd25; qb.push_back(32'h0);
    tick();
    waddrb = 5'd0; raddr1b = 5'd0; qb.push_back(32'h0);
    tick();
    waddrb = 5'd19; wdatab = 32'h19191919; raddr1b = 5'd19; qb.push_back(32'h19191919);
    tick();
    web = 0; re1b = 0;
    rdb(5'd25, 32'h0);
    rdb(5'd19, 32'h19191919);
    rdb(5'd0, 32'h0);

    // Sweep clear
    for (int i = 0; i < 32; i++) wr(5'(i), 32'hFFFFFFFF, 4'hF);
    rd1(5'd31, 32'hFFFFFFFF);
    rd2(5'd0, 32'h0);
    clr_req = 1; we = 1; waddr = 5'd9; wdata = 32'h55; wbe = 4'hF;
    tick();
    clr_req = 0; we = 0;
    n = 0; dn = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (clr_done === 1'b1) dn++;
      if (n == 4) begin
        we = 1; waddr = 5'd30; wdata = 32'h12345678; wbe = 4'hF;
        re1 = 1; raddr1 = 5'd30; fwd_en = 1; q1.push_back(32'hFFFFFFFF);
      end
      if (n == 10) clr_req = 1;
      tick();
      n++;
      we = 0; re1 = 0; clr_req = 0; fwd_en = 0;
    end
    check("sweep_busy_len", 32'(n), 32'd32);
    check("sweep_done_early", 32'(dn), 32'd0);
    check("sweep_done_pulse", 32'(clr_done), 32'h1);
    clr_req = 1;
    tick();
    clr_req = 0;
    check("done_req_ignored", 32'(clr_busy), 32'h0);
    check("done_one_cycle", 32'(clr_done), 32'h0);
    for (int i = 0; i < 32; i += 2) begin
      re1 = 1; raddr1 = 5'(i);     q1.push_back(32'h0);
      re2 = 1; raddr2 = 5'(i + 1); q2.push_back(32'h0);
      tick();
    end
    re1 = 0; re2 = 0;

    // Reset mid-sweep
    wr(5'd25, 32'hA5A5A5A5, 4'hF);
    wr(5'd2, 32'hA5A5A5A5, 4'hF);
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (10) tick();
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(clr_busy), 32'h0);
    tick();
    rst = 1'b1;
    dn = 0;
    repeat (40) begin
      tick();
      if (clr_done === 1'b1) dn++;
    end
    check("rst_mid_no_done", 32'(dn), 32'd0);
    rd1(5'd25, 32'h0);
    rd2(5'd2, 32'h0);
    wr(5'd12, 32'h77, 4'hF);
    rd1(5'd12, 32'h77);
    clr_req = 1;
    tick();
    clr_req = 0;
    measure_busy(n, dn);
    check("restart_busy_len", 32'(n), 32'd32);
    tick();
    rd1(5'd12, 32'h0);

    repeat (3) tick();
    check("scoreboard_drained", 32'(q1.size() + q2.size() + qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
